// File: rtl/srcsa_pkg.sv
// srcsa_pkg: shared constants for the 26-bit square-root carry-select adder/subtractor.
package srcsa_pkg;
   localparam int WIDTH = 26;
   localparam logic [4:0][4:0] BLK_W   = {5'd7, 5'd6, 5'd5, 5'd4, 5'd4};
   localparam logic [4:0][4:0] BLK_LSB = {5'd19, 5'd13, 5'd8, 5'd4, 5'd0};
endpackage

// File: rtl/srcsa_26bit_sub_pipe_csel_block.sv
// csel_block: N-bit ripple adder evaluated for both carry-in values.
module csel_block #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_sum0,
   output logic [N-1:0] o_sum1,
   output logic         o_cout0,
   output logic         o_cout1
);
   logic [N:0] w_c0, w_c1;
   assign w_c0[0] = 1'b0;
   assign w_c1[0] = 1'b1;
   for (genvar i = 0; i < N; i++) begin : g_fa
      assign o_sum0[i]  = i_a[i] ^ i_b[i] ^ w_c0[i];
      assign o_sum1[i]  = i_a[i] ^ i_b[i] ^ w_c1[i];
      assign w_c0[i+1]  = (i_a[i] & i_b[i]) | (w_c0[i] & (i_a[i] ^ i_b[i]));
      assign w_c1[i+1]  = (i_a[i] & i_b[i]) | (w_c1[i] & (i_a[i] ^ i_b[i]));
   end
   assign o_cout0 = w_c0[N];
   assign o_cout1 = w_c1[N];
endmodule

// File: rtl/srcsa_26bit_sub_pipe.sv
// srcsa_26bit_sub_pipe: 2-stage carry-select subtractor diff = a - b - borrow_in
// with valid/ready flow control; the condition-sum split straddles the two stages.
module srcsa_26bit_sub_pipe
   import srcsa_pkg::*;
#(
   parameter int WIDTH               = 26,
   parameter bit CLEAR_DATA_ON_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);
   logic             w_s1_en, w_s2_en, w_cin, w_b0_c;
   logic [3:0]       w_b0_sum;
   logic [WIDTH-1:0] w_bn, w_diff;
   logic [4:0][3:0]  w_ls0, w_ls1;
   logic [4:0]       w_lc0, w_lc1, w_c;
   logic [5:0]       w_ua, w_ub;
   logic             r_s1_valid, r_s1_b0_c;
   logic [3:0]       r_s1_b0_sum;
   logic [3:0][3:0]  r_s1_ls0, r_s1_ls1;
   logic [3:0]       r_s1_lc0, r_s1_lc1;
   logic [5:0]       r_s1_ua, r_s1_ub;

   assign w_s2_en  = ~out_valid | out_ready;
   assign w_s1_en  = ~r_s1_valid | w_s2_en;
   assign in_ready = w_s1_en;
   assign w_bn     = ~b;
   assign w_cin    = ~borrow_in;

   for (genvar k = 0; k < 5; k++) begin : g_lo
      csel_block #(.N(4)) u_lo (
         .i_a(a[BLK_LSB[k] +: 4]), .i_b(w_bn[BLK_LSB[k] +: 4]),
         .o_sum0(w_ls0[k]), .o_sum1(w_ls1[k]), .o_cout0(w_lc0[k]), .o_cout1(w_lc1[k]));
   end
   assign w_b0_sum = w_cin ? w_ls1[0] : w_ls0[0];
   assign w_b0_c   = w_cin ? w_lc1[0] : w_lc0[0];
   // Upper bits of B2..B4 packed LSB-first: bit 12 | bits 18:17 | bits 25:23
   assign w_ua = {a[25:23], a[18:17], a[12]};
   assign w_ub = {w_bn[25:23], w_bn[18:17], w_bn[12]};

   always_ff @(posedge clk) begin
      if (!reset) r_s1_valid <= 1'b0;
      else if (w_s1_en) r_s1_valid <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (!reset && CLEAR_DATA_ON_RESET) begin
         r_s1_b0_sum <= '0;
         r_s1_b0_c   <= 1'b0;
         r_s1_ls0    <= '0;
         r_s1_ls1    <= '0;
         r_s1_lc0    <= '0;
         r_s1_lc1    <= '0;
         r_s1_ua     <= '0;
         r_s1_ub     <= '0;
      end else if (reset && w_s1_en && in_valid) begin
         r_s1_b0_sum <= w_b0_sum;
         r_s1_b0_c   <= w_b0_c;
         r_s1_ls0    <= w_ls0[4:1];
         r_s1_ls1    <= w_ls1[4:1];
         r_s1_lc0    <= w_lc0[4:1];
         r_s1_lc1    <= w_lc1[4:1];
         r_s1_ua     <= w_ua;
         r_s1_ub     <= w_ub;
      end
   end

   assign w_c[0]      = r_s1_b0_c;
   assign w_diff[3:0] = r_s1_b0_sum;
   assign w_diff[7:4] = w_c[0] ? r_s1_ls1[0] : r_s1_ls0[0];
   assign w_c[1]      = w_c[0] ? r_s1_lc1[0] : r_s1_lc0[0];

   for (genvar k = 2; k < 5; k++) begin : g_up
      localparam int U   = k - 1;
      localparam int OFF = (k - 2) * (k - 1) / 2;
      logic [U-1:0] w_us0, w_us1;
      logic         w_uc0, w_uc1;
      csel_block #(.N(U)) u_up (
         .i_a(r_s1_ua[OFF +: U]), .i_b(r_s1_ub[OFF +: U]),
         .o_sum0(w_us0), .o_sum1(w_us1), .o_cout0(w_uc0), .o_cout1(w_uc1));
      assign w_diff[BLK_LSB[k] +: BLK_W[k]] = w_c[k-1]
         ? {r_s1_lc1[k-1] ? w_us1 : w_us0, r_s1_ls1[k-1]}
         : {r_s1_lc0[k-1] ? w_us1 : w_us0, r_s1_ls0[k-1]};
      assign w_c[k] = w_c[k-1] ? (r_s1_lc1[k-1] ? w_uc1 : w_uc0)
                               : (r_s1_lc0[k-1] ? w_uc1 : w_uc0);
   end

   always_ff @(posedge clk) begin
      if (!reset) out_valid <= 1'b0;
      else if (w_s2_en) out_valid <= r_s1_valid;
   end

   // r_s1_ub holds ~b, so equal stored sign bits mean the operand signs differ
   always_ff @(posedge clk) begin
      if (!reset && CLEAR_DATA_ON_RESET) begin
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else if (reset && w_s2_en && r_s1_valid) begin
         diff       <= w_diff;
         borrow_out <= ~w_c[4];
         overflow   <= (r_s1_ua[5] == r_s1_ub[5]) && (w_diff[25] != r_s1_ua[5]);
      end
   end
endmodule
